// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin front end that time-shares one shift-add
// multiplier among NREQ requesters. A winner's operands are captured and
// issued to the multiplier (or short-circuited when either operand is zero),
// and the product is returned tagged with the requester index. A WAIT-state
// watchdog turns a multiplier that never completes into an error response.
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     opa,
    input  logic [NREQ*WIDTH-1:0]     opb,
    output logic [NREQ-1:0]           gnt,
    output logic                      mul_start,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    input  logic                      mul_complete,
    input  logic [2*WIDTH-1:0]        mul_product,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_product,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic                 mul_start_q, mul_start_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 complete_prev_q, complete_prev_d;

    // Per-requester operand views of the packed input buses
    logic [WIDTH-1:0] opa_arr [NREQ];
    logic [WIDTH-1:0] opb_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign opa_arr[gi] = opa[gi*WIDTH +: WIDTH];
        assign opb_arr[gi] = opb[gi*WIDTH +: WIDTH];
    end

    // Returns {found, index} of the first set request searching from p upward
    // with wrap-around. Walking the offsets downward lets the smallest offset
    // overwrite the result last, so it wins.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  p);
        logic [IDW:0] res;
        int           c;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = (int'(p) + k) % NREQ;
            if (r[c]) begin
                res = {1'b1, IDW'(c)};
            end
        end
        return res;
    endfunction

    logic [IDW:0]   pick;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;

    assign pick       = rr_pick(req, ptr_q);
    assign pick_found = pick[IDW];
    assign pick_idx   = pick[IDW-1:0];

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        gnt_d           = '0;
        mul_start_d     = 1'b0;
        mul_a_d         = mul_a_q;
        mul_b_d         = mul_b_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_id_d        = rsp_id_q;
        rsp_product_d   = rsp_product_q;
        rsp_err_d       = rsp_err_q;
        cnt_d           = cnt_q;
        // Sampling every cycle means the detector is re-armed with the
        // level seen on the last ISSUE cycle when WAIT is entered.
        complete_prev_d = mul_complete;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    mul_a_d  = opa_arr[pick_idx];
                    mul_b_d  = opb_arr[pick_idx];
                    rsp_id_d = pick_idx;
                    ptr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // First ISSUE cycle decides bypass vs. start; second one
                // (start pulse on the wire) hands over to WAIT.
                if (!mul_start_q) begin
                    if ((mul_a_q == '0) || (mul_b_q == '0)) begin
                        rsp_product_d = '0;
                        rsp_err_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        state_d       = RESP;
                    end else begin
                        mul_start_d = 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion edge takes priority over an expiring watchdog.
                if (mul_complete && !complete_prev_q) begin
                    rsp_product_d = mul_product;
                    rsp_err_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_product_d = '0;
                    rsp_err_d     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; async reset abandons any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            gnt_q           <= '0;
            mul_start_q     <= 1'b0;
            mul_a_q         <= '0;
            mul_b_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_product_q   <= '0;
            rsp_err_q       <= 1'b0;
            busy_q          <= 1'b0;
            cnt_q           <= '0;
            complete_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            gnt_q           <= gnt_d;
            mul_start_q     <= mul_start_d;
            mul_a_q         <= mul_a_d;
            mul_b_q         <= mul_b_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_product_q   <= rsp_product_d;
            rsp_err_q       <= rsp_err_d;
            busy_q          <= busy_d;
            cnt_q           <= cnt_d;
            complete_prev_q <= complete_prev_d;
        end
    end

    assign gnt         = gnt_q;
    assign mul_start   = mul_start_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed testbench for mul_share_arbiter with a behavioural multiplier
// that raises complete for one cycle, five cycles after a start pulse.
module tb_mul_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*WIDTH-1:0]  opa = '0;
    logic [NREQ*WIDTH-1:0]  opb = '0;
    logic [NREQ-1:0]        gnt;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic                   mul_complete;
    logic [2*WIDTH-1:0]     mul_product;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [1:0]             rsp_id;
    logic [2*WIDTH-1:0]     rsp_product;
    logic                   rsp_err;
    logic                   busy;

    int pass_count  = 0;
    int total_count = 0;

    // Multiplier model
    logic       model_en = 1'b1;
    logic       model_complete;
    logic       inject_complete = 1'b0;
    logic [2:0] cd;

    assign mul_complete = model_complete | inject_complete;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb), .gnt(gnt),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_complete(mul_complete), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cd             <= '0;
            model_complete <= 1'b0;
            mul_product    <= '0;
        end else begin
            model_complete <= 1'b0;
            if (mul_start && model_en) begin
                cd          <= 3'd4;
                mul_product <= {16'h0, mul_a} * {16'h0, mul_b};
            end else if (cd != 0) begin
                cd <= cd - 1'b1;
                if (cd == 3'd1) model_complete <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        opa[i*WIDTH +: WIDTH] = a;
        opb[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_rsp(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic accept();
        $display("rsp id=%0d product=%h err=%b", rsp_id, rsp_product, rsp_err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total_count++; if ({gnt, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, rsp_err, busy} !== '0)
            $display("FAIL reset_outputs: got gnt=%b st=%b a=%h b=%h v=%b id=%0d p=%h e=%b busy=%b want all 0",
                     gnt, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, rsp_err, busy);
        else pass_count++;
        rst = 1'b0;
        tick();
        total_count++; if (busy !== 1'b0 || gnt !== 4'b0000) $display("FAIL reset_idle: busy=%b gnt=%b want 0/0000", busy, gnt); else pass_count++;
    endtask

    task automatic test_round_robin();
        int got [8];
        int exp_order [8];
        int n;
        bit ok;
        exp_order = '{0, 1, 2, 3, 0, 1, 3, 1};
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 1), 16'd3);
        rsp_ready = 1'b1;
        req = 4'b1111;
        n = 0;
        for (int c = 0; c < 400 && n < 5; c++) begin
            tick();
            if (gnt != 0) begin got[n] = onehot_idx(gnt); n++; end
        end
        req = 4'b1010;
        for (int c = 0; c < 400 && n < 8; c++) begin
            tick();
            if (gnt != 0) begin got[n] = onehot_idx(gnt); n++; end
        end
        req = 4'b0000;
        total_count++; if (n != 8) $display("FAIL rr_count: got %0d grants want 8", n); else pass_count++;
        for (int k = 0; k < 8; k++) begin
            total_count++; if (got[k] !== exp_order[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, got[k], exp_order[k]); else pass_count++;
        end
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy && !rsp_valid) begin ok = 1'b1; break; end
            tick();
        end
        total_count++; if (!ok) $display("FAIL rr_drain: busy=%b want 0 within 100 cycles", busy); else pass_count++;
        rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_ops(0, 16'd7, 16'd6);
        req = 4'b0001;
        tick();
        total_count++; if (gnt !== 4'b0001 || busy !== 1'b1) $display("FAIL single_gnt: gnt=%b busy=%b want 0001/1", gnt, busy); else pass_count++;
        req = 4'b0000;
        tick();
        total_count++; if (mul_start !== 1'b1 || mul_a !== 16'd7 || mul_b !== 16'd6)
            $display("FAIL single_start: start=%b a=%0d b=%0d want 1/7/6", mul_start, mul_a, mul_b);
        else pass_count++;
        repeat (5) tick();
        total_count++; if (rsp_valid !== 1'b0 || mul_start !== 1'b0) $display("FAIL single_early: valid=%b start=%b at cycle 7 want 0/0", rsp_valid, mul_start); else pass_count++;
        tick();
        total_count++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 32'd42 || rsp_err !== 1'b0)
            $display("FAIL single_rsp: valid=%b id=%0d p=%0d err=%b want 1/0/42/0", rsp_valid, rsp_id, rsp_product, rsp_err);
        else pass_count++;
        accept();
        total_count++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL single_done: busy=%b valid=%b want 0/0", busy, rsp_valid); else pass_count++;
    endtask

    task automatic test_zero_bypass();
        bit saw_start;
        saw_start = 1'b0;
        set_ops(2, 16'd0, 16'd9);
        req = 4'b0100;
        tick();
        saw_start |= mul_start;
        total_count++; if (gnt !== 4'b0100) $display("FAIL zero_gnt: got %b want 0100", gnt); else pass_count++;
        req = 4'b0000;
        tick();
        saw_start |= mul_start;
        total_count++; if (rsp_valid !== 1'b1 || rsp_product !== 32'd0 || rsp_id !== 2'd2 || rsp_err !== 1'b0)
            $display("FAIL zero_rsp: valid=%b p=%h id=%0d err=%b want 1/0/2/0", rsp_valid, rsp_product, rsp_id, rsp_err);
        else pass_count++;
        accept();
        saw_start |= mul_start;
        tick();
        saw_start |= mul_start;
        total_count++; if (saw_start !== 1'b0) $display("FAIL zero_nostart: mul_start seen=%b want 0", saw_start); else pass_count++;
    endtask

    task automatic test_timeout();
        bit ok;
        model_en = 1'b0;
        set_ops(1, 16'd5, 16'd5);
        req = 4'b0010;
        tick();
        total_count++; if (gnt !== 4'b0010) $display("FAIL to_gnt: got %b want 0010", gnt); else pass_count++;
        req = 4'b0000;
        repeat (65) tick();
        total_count++; if (rsp_valid !== 1'b0) $display("FAIL to_early: valid=%b at cycle 66 want 0", rsp_valid); else pass_count++;
        tick();
        total_count++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_product !== 32'd0 || rsp_id !== 2'd1)
            $display("FAIL to_rsp: valid=%b err=%b p=%h id=%0d want 1/1/0/1", rsp_valid, rsp_err, rsp_product, rsp_id);
        else pass_count++;
        accept();
        model_en = 1'b1;
        set_ops(1, 16'd3, 16'd4);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        wait_rsp(20, ok);
        total_count++; if (!ok || rsp_product !== 32'd12 || rsp_err !== 1'b0)
            $display("FAIL to_recover: valid=%b p=%0d err=%b want 1/12/0", rsp_valid, rsp_product, rsp_err);
        else pass_count++;
        accept();
    endtask

    task automatic test_back_to_back_backpressure();
        bit ok;
        bit stable;
        bit any_gnt;
        set_ops(0, 16'd2, 16'd9);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        wait_rsp(20, ok);
        total_count++; if (!ok || rsp_product !== 32'd18) $display("FAIL bp_first: valid=%b p=%0d want 1/18", rsp_valid, rsp_product); else pass_count++;
        set_ops(1, 16'd4, 16'd5);
        req = 4'b0010;
        stable = 1'b1;
        any_gnt = 1'b0;
        repeat (10) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_product !== 32'd18 || rsp_id !== 2'd0 || rsp_err !== 1'b0) stable = 1'b0;
            if (gnt !== 4'b0000) any_gnt = 1'b1;
        end
        total_count++; if (!stable) $display("FAIL bp_stable: valid=%b p=%0d id=%0d want 1/18/0 held", rsp_valid, rsp_product, rsp_id); else pass_count++;
        total_count++; if (any_gnt) $display("FAIL bp_nognt: grant seen=%b want 0", any_gnt); else pass_count++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total_count++; if (rsp_valid !== 1'b0 || gnt !== 4'b0000) $display("FAIL bp_accept: valid=%b gnt=%b want 0/0000", rsp_valid, gnt); else pass_count++;
        tick();
        total_count++; if (gnt !== 4'b0010) $display("FAIL bp_next_gnt: got %b want 0010", gnt); else pass_count++;
        req = 4'b0000;
        wait_rsp(20, ok);
        total_count++; if (!ok || rsp_product !== 32'd20 || rsp_id !== 2'd1) $display("FAIL bp_second: valid=%b p=%0d id=%0d want 1/20/1", rsp_valid, rsp_product, rsp_id); else pass_count++;
        accept();
        inject_complete = 1'b1;
        tick();
        inject_complete = 1'b0;
        tick();
        tick();
        total_count++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL stale_complete: busy=%b valid=%b want 0/0", busy, rsp_valid); else pass_count++;
    endtask

    task automatic test_async_reset();
        bit ok;
        set_ops(2, 16'd3, 16'd3);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (3) tick();
        total_count++; if (busy !== 1'b1 || mul_a !== 16'd3) $display("FAIL ar_inflight: busy=%b a=%0d want 1/3", busy, mul_a); else pass_count++;
        #2 rst = 1'b1;
        #1;
        total_count++; if ({gnt, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_product, rsp_err, busy} !== '0)
            $display("FAIL ar_outputs: busy=%b a=%h b=%h v=%b id=%0d want all 0", busy, mul_a, mul_b, rsp_valid, rsp_id);
        else pass_count++;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        set_ops(0, 16'd1, 16'd1);
        set_ops(3, 16'hFFFF, 16'hFFFF);
        req = 4'b1001;
        tick();
        total_count++; if (gnt !== 4'b0001) $display("FAIL ar_ptr0: got %b want 0001", gnt); else pass_count++;
        req = 4'b1000;
        wait_rsp(20, ok);
        total_count++; if (!ok || rsp_product !== 32'd1 || rsp_id !== 2'd0) $display("FAIL ar_rsp0: valid=%b p=%h id=%0d want 1/1/0", rsp_valid, rsp_product, rsp_id); else pass_count++;
        accept();
        tick();
        total_count++; if (gnt !== 4'b1000) $display("FAIL ar_gnt3: got %b want 1000", gnt); else pass_count++;
        req = 4'b0000;
        wait_rsp(20, ok);
        total_count++; if (!ok || rsp_product !== 32'hFFFE0001 || rsp_id !== 2'd3 || rsp_err !== 1'b0)
            $display("FAIL ar_maxprod: valid=%b p=%h id=%0d err=%b want 1/fffe0001/3/0", rsp_valid, rsp_product, rsp_id, rsp_err);
        else pass_count++;
        accept();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_bypass();
        test_timeout();
        test_back_to_back_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_count, total_count);
        $fatal(1, "watchdog");
    end

endmodule
